camera_stream_gen: RTL and testbench

- Emulates the OV7670-style parallel camera output: pixel clock, VSYNC, HREF and 8-bit RGB565 byte stream.
- Drives test patterns into the camera reader and frame-buffer path, so capture can be verified on the board and in simulation without a physical camera.
- Transmit end of the DVP interface that the capture logic receives.

---
 rtl/camera_pkg.sv | 25 ++
 rtl/camera_pattern_rom.sv | 24 ++
 rtl/camera_stream_gen.sv | 139 +++++++++++++
 tb/tb_camera_stream_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the emulated DVP camera source.
package camera_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_FCNT  = 2'd3
    } pattern_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
    localparam logic [7:0][15:0] BAR_RGB = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/camera_pattern_rom.sv
// Combinational RGB565 pixel generator for the selected test pattern.
module camera_pattern_rom
    import camera_pkg::*;
(
    input  logic [1:0]  pattern,
    input  logic [2:0]  bar,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [7:0]  fcnt,
    output logic [15:0] pix
);

    always_comb begin
        pix = 16'h0000;
        case (pattern_t'(pattern))
            PAT_SOLID: pix = 16'hF800;
            PAT_BARS:  pix = BAR_RGB[bar];
            PAT_RAMP:  pix = {x, y};
            PAT_FCNT:  pix = {fcnt, x};
            default:   pix = 16'h0000;
        endcase
    end

endmodule

// File: rtl/camera_stream_gen.sv
// OV7670-style parallel camera emulator: pclk, vsync, href and RGB565 bytes.
module camera_stream_gen
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int BAR_W       = 80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] pattern,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic       frame_start,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int LINE_W  = 2 * H_ACTIVE + H_BLANK;
    localparam int Y0      = VSYNC_LINES + V_BACK;
    localparam int FRAME_L = Y0 + V_ACTIVE + V_FRONT;
    localparam int BX_W    = $clog2(LINE_W);
    localparam int LN_W    = $clog2(FRAME_L);
    localparam int BC_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    state_t            state, nstate;
    logic [BX_W-1:0]   byte_x, nbyte_x;
    logic [LN_W-1:0]   line, nline;
    logic [2:0]        bar_idx, nbar_idx;
    logic [BC_W-1:0]   bar_cnt, nbar_cnt;
    logic [1:0]        pat_q;
    logic              frame_end;
    logic              href_n;
    logic [15:0]       pix;

    // Everything below is evaluated for the byte that starts at the next
    // boundary, so outputs can be registered directly on that edge.
    always_comb begin
        nstate    = state;
        nbyte_x   = byte_x;
        nline     = line;
        nbar_idx  = bar_idx;
        nbar_cnt  = bar_cnt;
        frame_end = 1'b0;
        if (pclk) begin
            if (state == ST_IDLE) begin
                nbyte_x = '0;
                nline   = '0;
                if (enable) nstate = ST_VSYNC;
            end else if (byte_x == BX_W'(LINE_W - 1)) begin
                nbyte_x = '0;
                nline   = (line == LN_W'(FRAME_L - 1)) ? '0 : line + 1'b1;
                case (state)
                    ST_VSYNC:  if (line == LN_W'(VSYNC_LINES - 1)) nstate = ST_VBACK;
                    ST_VBACK:  if (line == LN_W'(Y0 - 1)) nstate = ST_ACTIVE;
                    ST_ACTIVE: if (line == LN_W'(Y0 + V_ACTIVE - 1)) nstate = ST_VFRONT;
                    ST_VFRONT: if (line == LN_W'(FRAME_L - 1)) begin
                        frame_end = 1'b1;
                        nstate    = enable ? ST_VSYNC : ST_IDLE;
                    end
                    default: ;
                endcase
            end else begin
                nbyte_x = byte_x + 1'b1;
            end
            // Bar index tracks x incrementally; it saturates at the last bar.
            if (nbyte_x == '0) begin
                nbar_idx = '0;
                nbar_cnt = '0;
            end else if (!nbyte_x[0]) begin
                if (bar_cnt == BC_W'(BAR_W - 1)) begin
                    nbar_cnt = '0;
                    if (bar_idx != 3'd7) nbar_idx = bar_idx + 1'b1;
                end else begin
                    nbar_cnt = bar_cnt + 1'b1;
                end
            end
        end
    end

    assign href_n = (nstate == ST_ACTIVE) && (nbyte_x < BX_W'(2 * H_ACTIVE));

    camera_pattern_rom u_rom (
        .pattern (pat_q),
        .bar     (nbar_idx),
        .x       (8'(nbyte_x >> 1)),
        .y       (8'(nline - LN_W'(Y0))),
        .fcnt    (frame_cnt),
        .pix     (pix)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nstate;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pclk        <= 1'b0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            data        <= 8'h00;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 8'h00;
            byte_x      <= '0;
            line        <= '0;
            bar_idx     <= '0;
            bar_cnt     <= '0;
            pat_q       <= '0;
        end else begin
            pclk        <= ~pclk;
            frame_start <= 1'b0;
            if (pclk) begin
                byte_x  <= nbyte_x;
                line    <= nline;
                bar_idx <= nbar_idx;
                bar_cnt <= nbar_cnt;
                vsync   <= (nstate == ST_VSYNC);
                busy    <= (nstate != ST_IDLE);
                href    <= href_n;
                data    <= href_n ? (nbyte_x[0] ? pix[7:0] : pix[15:8]) : 8'h00;
                if (frame_end) frame_cnt <= frame_cnt + 8'd1;
                if (nstate == ST_VSYNC && state != ST_VSYNC) begin
                    frame_start <= 1'b1;
                    pat_q       <= pattern;
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_stream_gen.sv
// Directed bench for camera_stream_gen using a shrunk 8x4 frame geometry.
module tb_camera_stream_gen;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] pattern;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_start;
    logic       busy;
    logic [7:0] frame_cnt;

    camera_stream_gen #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1),
        .V_BACK(1), .V_FRONT(1), .BAR_W(1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pattern     (pattern),
        .pclk        (pclk),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] cap [0:63];
    int nb, vs_cnt, hr_cnt, hr_pulses, busy_low, blank_nz, lat;

    logic [7:0] bars_line [0:15] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
        8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records one 280-clk frame starting at its frame_start sample.
    task automatic capture_frame(input bit at_start, input logic [1:0] next_pat, input int drop_at);
        bit found;
        bit prev;
        found = at_start;
        prev = 1'b0;
        lat = 0;
        nb = 0; vs_cnt = 0; hr_cnt = 0; hr_pulses = 0; busy_low = 0; blank_nz = 0;
        while (!found && lat < 600) begin
            @(posedge clk); #1;
            lat++;
            found = frame_start;
        end
        chk("frame_start_seen", 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < 280; i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                if (i == 100) pattern = next_pat;
                if (i == drop_at) enable = 1'b0;
                if (vsync) vs_cnt++;
                if (href) hr_cnt++;
                if (href && !prev) hr_pulses++;
                if (!href && data != 8'h00) blank_nz++;
                if (!busy) busy_low++;
                if (href && pclk && nb < 64) begin
                    cap[nb] = data;
                    nb++;
                end
                prev = href;
            end
        end
    endtask

    task automatic frame_basic(input string tag);
        chk({tag, "_vsync_clks"}, 32'(vs_cnt), 32'd40);
        chk({tag, "_href_clks"}, 32'(hr_cnt), 32'd128);
        chk({tag, "_href_pulses"}, 32'(hr_pulses), 32'd4);
        chk({tag, "_bytes"}, 32'(nb), 32'd64);
        chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
        chk({tag, "_blank_data"}, 32'(blank_nz), 32'd0);
    endtask

    task automatic check_fcnt_bytes(input string tag, input logic [7:0] fc);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (cap[i] !== (i[0] ? 8'(i[3:1]) : fc)) bad++;
        chk({tag, "_pixels"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        int vs_after;
        int toggles;
        logic prev_p;

        reset_n = 1'b0;
        enable  = 1'b0;
        pattern = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pclk", 32'(pclk), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_href", 32'(href), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // Solid red; pattern switched to bars mid-frame must not affect it.
        enable = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        capture_frame(1'b0, 2'd1, -1);
        chk("solid_latency", 32'(lat), 32'd2);
        frame_basic("solid");
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (cap[i] !== (i[0] ? 8'h00 : 8'hF8)) bad++;
        chk("solid_pixels", 32'(bad), 32'd0);

        // Colour bars, immediately following.
        capture_frame(1'b0, 2'd2, -1);
        chk("bars_back_to_back", 32'(lat), 32'd1);
        frame_basic("bars");
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (cap[i] !== bars_line[i % 16]) bad++;
        chk("bars_pixels", 32'(bad), 32'd0);

        // XY ramp: {x, y}, high byte first.
        capture_frame(1'b0, 2'd2, -1);
        frame_basic("ramp");
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (cap[i] !== (i[0] ? 8'(i / 16) : 8'((i % 16) / 2))) bad++;
        chk("ramp_pixels", 32'(bad), 32'd0);
        chk("ramp_y2_byte1", 32'(cap[33]), 32'h02);
        chk("ramp_y2_byte14", 32'(cap[46]), 32'h07);
        chk("ramp_frame_cnt", 32'(frame_cnt), 32'd2);

        // Reset in the middle of the first active line of the next frame.
        repeat (91) @(posedge clk);
        #1;
        chk("pre_reset_href", 32'(href), 32'd1);
        pattern = 2'd3;
        enable  = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("async_vsync", 32'(vsync), 32'd0);
        chk("async_href", 32'(href), 32'd0);
        chk("async_data", 32'(data), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Frame counter pattern over three frames after reset.
        capture_frame(1'b0, 2'd3, -1);
        chk("fcnt0_latency", 32'(lat), 32'd2);
        frame_basic("fcnt0");
        check_fcnt_bytes("fcnt0", 8'h00);
        capture_frame(1'b0, 2'd3, -1);
        check_fcnt_bytes("fcnt1", 8'h01);
        capture_frame(1'b0, 2'd3, -1);
        check_fcnt_bytes("fcnt2", 8'h02);
        @(posedge clk); #1;
        chk("frame_cnt_after3", 32'(frame_cnt), 32'd3);
        chk("next_frame_start", 32'(frame_start), 32'd1);

        // Drop enable during the second active line; frame must finish whole.
        capture_frame(1'b1, 2'd3, 130);
        frame_basic("drop");
        check_fcnt_bytes("drop", 8'h03);
        @(posedge clk); #1;
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_vsync", 32'(vsync), 32'd0);
        chk("drop_frame_cnt", 32'(frame_cnt), 32'd4);
        vs_after = 0;
        toggles  = 0;
        prev_p   = pclk;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (vsync || frame_start || busy) vs_after++;
            if (pclk != prev_p) toggles++;
            prev_p = pclk;
        end
        chk("idle_no_frame", 32'(vs_after), 32'd0);
        chk("idle_pclk_toggles", 32'(toggles), 32'd300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
